// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: default sizes,
// opcode values, instruction word layout and FSM state encoding.
package inst_sequencer_pkg;

    localparam int IMEM_DEPTH_DEF = 32;
    localparam int ADDR_W_DEF     = 5;
    localparam int RPT_W_DEF      = 8;
    localparam int PIPE_DEPTH_DEF = 7;
    localparam int OUTST_W_DEF    = 4;

    // Instruction word: {opcode[2:0], repeat_minus_one[RPT_W-1:0]}
    localparam int OPC_W   = 3;
    localparam int RPT_LSB = 0;

    typedef enum logic [2:0] {
        OP_LOAD   = 3'b000,
        OP_ADD    = 3'b001,
        OP_SUB    = 3'b010,
        OP_MUL    = 3'b100,
        OP_MULADD = 3'b101,
        OP_MULSUB = 3'b110,
        OP_MAX    = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/inst_sequencer_outstanding_tracker.sv
// Up/down counter of decoder operations in flight. Flags a return with
// nothing outstanding (counter held at zero) and a count beyond the
// decoder pipeline depth (counter saturates instead of wrapping).
module outstanding_tracker #(
    parameter int CNT_W   = 4,
    parameter int MAX_OUT = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_i,
    input  logic             ret_i,
    output logic [CNT_W-1:0] count_next_o,
    output logic             underflow_o,
    output logic             overflow_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count and error detection; simultaneous issue and return cancel.
    always_comb begin
        count_d     = count_q;
        underflow_o = 1'b0;
        overflow_o  = 1'b0;
        if (issue_i && !ret_i) begin
            if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
            if (count_q >= CNT_W'(MAX_OUT)) begin
                overflow_o = 1'b1;
            end
        end else if (ret_i && !issue_i) begin
            if (count_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_next_o = count_d;

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: steps through a host-loaded program memory,
// expanding each word's repeat count into back-to-back decoder issues,
// then waits for all results to return before pulsing done.
// Optional build macro INST_SEQ_LOOP_EN adds loop_cnt for repeated passes.
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int RPT_W      = RPT_W_DEF,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
    parameter int OUTST_W    = OUTST_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [RPT_W+2:0]  wr_data,
    input  logic [ADDR_W-1:0] prog_len,
    input  logic              start,
    input  logic              stall,
    input  logic              ret_v,
`ifdef INST_SEQ_LOOP_EN
    input  logic [7:0]        loop_cnt,
`endif
    output logic              inst_v,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              err
);

    logic [RPT_W+2:0] imem [IMEM_DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [RPT_W-1:0]  rpt_q, rpt_d;
    logic              inst_v_q, inst_v_d;
    logic [2:0]        opcode_q, opcode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef INST_SEQ_LOOP_EN
    logic [7:0]        loop_q, loop_d;
`endif

    logic [ADDR_W-1:0] pc_inc;
    logic [OUTST_W-1:0] outst_next;
    logic              underflow;
    logic              overflow;

    assign pc_inc = pc_q + 1'b1;

    // Program memory write port; contents are not reset and are only
    // writable while idle so a running program cannot be corrupted.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == ST_IDLE)) begin
            imem[wr_addr] <= wr_data;
        end
    end

    outstanding_tracker #(
        .CNT_W   (OUTST_W),
        .MAX_OUT (PIPE_DEPTH)
    ) u_track (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_i      (inst_v_q),
        .ret_i        (ret_v),
        .count_next_o (outst_next),
        .underflow_o  (underflow),
        .overflow_o   (overflow)
    );

    // Next-state and output logic; drain completes on the cycle whose
    // return brings the in-flight count to zero.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        rpt_d    = rpt_q;
        inst_v_d = 1'b0;
        opcode_d = opcode_q;
        done_d   = 1'b0;
`ifdef INST_SEQ_LOOP_EN
        loop_d   = loop_q;
`endif
        err_d    = err_q | (wr_en && (state_q != ST_IDLE)) | underflow | overflow;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    len_d   = prog_len;
                    rpt_d   = imem[0][RPT_W-1:RPT_LSB];
`ifdef INST_SEQ_LOOP_EN
                    loop_d  = loop_cnt;
`endif
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    inst_v_d = 1'b1;
                    opcode_d = imem[pc_q][RPT_W+OPC_W-1:RPT_W];
                    if (rpt_q != '0) begin
                        rpt_d = rpt_q - 1'b1;
                    end else if (pc_q != len_q) begin
                        pc_d  = pc_inc;
                        rpt_d = imem[pc_inc][RPT_W-1:RPT_LSB];
                    end
`ifdef INST_SEQ_LOOP_EN
                    else if (loop_q != '0) begin
                        loop_d = loop_q - 1'b1;
                        pc_d   = '0;
                        rpt_d  = imem[0][RPT_W-1:RPT_LSB];
                    end
`endif
                    else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (outst_next == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any run immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            rpt_q    <= '0;
            inst_v_q <= 1'b0;
            opcode_q <= OP_LOAD;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef INST_SEQ_LOOP_EN
            loop_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            rpt_q    <= rpt_d;
            inst_v_q <= inst_v_d;
            opcode_q <= opcode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef INST_SEQ_LOOP_EN
            loop_q   <= loop_d;
`endif
        end
    end

    assign inst_v = inst_v_q;
    assign opcode = opcode_q;
    assign pc     = pc_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule
